// File: rtl/cpu_pkg.sv
// Shared definitions for the hardwired control unit.
//   - opcode values decoded from ir[31:27]
//   - OP_INCPC, the ALU code for Z = BusMuxOut + 1 used during fetch
//   - sequencer state enum and step constants T0..T9
//   - ctrl_t, the bundle of every datapath strobe plus the ALU operation
package cpu_pkg;

  localparam int OP_W   = 5;
  localparam int STEP_W = 4;

  localparam logic [OP_W-1:0] OP_INCPC = 5'b11111;

  localparam logic [OP_W-1:0] OP_LD   = 5'b00000;
  localparam logic [OP_W-1:0] OP_LDI  = 5'b00001;
  localparam logic [OP_W-1:0] OP_ST   = 5'b00010;
  localparam logic [OP_W-1:0] OP_ADD  = 5'b00011;
  localparam logic [OP_W-1:0] OP_SUB  = 5'b00100;
  localparam logic [OP_W-1:0] OP_AND  = 5'b00101;
  localparam logic [OP_W-1:0] OP_OR   = 5'b00110;
  localparam logic [OP_W-1:0] OP_ROR  = 5'b00111;
  localparam logic [OP_W-1:0] OP_ROL  = 5'b01000;
  localparam logic [OP_W-1:0] OP_SHR  = 5'b01001;
  localparam logic [OP_W-1:0] OP_SHRA = 5'b01010;
  localparam logic [OP_W-1:0] OP_SHL  = 5'b01011;
  localparam logic [OP_W-1:0] OP_ADDI = 5'b01100;
  localparam logic [OP_W-1:0] OP_ANDI = 5'b01101;
  localparam logic [OP_W-1:0] OP_ORI  = 5'b01110;
  localparam logic [OP_W-1:0] OP_DIV  = 5'b01111;
  localparam logic [OP_W-1:0] OP_MUL  = 5'b10000;
  localparam logic [OP_W-1:0] OP_NEG  = 5'b10001;
  localparam logic [OP_W-1:0] OP_NOT  = 5'b10010;
  localparam logic [OP_W-1:0] OP_BR   = 5'b10011;
  localparam logic [OP_W-1:0] OP_JR   = 5'b10100;
  localparam logic [OP_W-1:0] OP_JAL  = 5'b10101;
  localparam logic [OP_W-1:0] OP_IN   = 5'b10110;
  localparam logic [OP_W-1:0] OP_OUT  = 5'b10111;
  localparam logic [OP_W-1:0] OP_MFHI = 5'b11000;
  localparam logic [OP_W-1:0] OP_MFLO = 5'b11001;
  localparam logic [OP_W-1:0] OP_NOP  = 5'b11010;
  localparam logic [OP_W-1:0] OP_HALT = 5'b11011;

  typedef enum logic [1:0] {RESET, FETCH, EXEC, HALT} state_t;

  localparam logic [STEP_W-1:0] T0 = 4'd0;
  localparam logic [STEP_W-1:0] T1 = 4'd1;
  localparam logic [STEP_W-1:0] T2 = 4'd2;
  localparam logic [STEP_W-1:0] T3 = 4'd3;
  localparam logic [STEP_W-1:0] T4 = 4'd4;
  localparam logic [STEP_W-1:0] T5 = 4'd5;
  localparam logic [STEP_W-1:0] T6 = 4'd6;
  localparam logic [STEP_W-1:0] T7 = 4'd7;
  localparam logic [STEP_W-1:0] T8 = 4'd8;
  localparam logic [STEP_W-1:0] T9 = 4'd9;

  typedef struct packed {
    logic PCout, ZHighout, Zlowout, HIout, LOout, InPortout, MDRout, Cout;
    logic PCin, MARin, MDRin, IRin, Yin, HIin, LOin, ZHIin, ZLOin, CONin, OutPortin;
    logic Gra, Grb, Grc, Rin, Rout, BAout;
    logic Read, Write;
    logic [OP_W-1:0] operation;
  } ctrl_t;

  // Every code up to mflo has execute steps; nop, halt and the unused
  // codes above halt finish at T3.
  function automatic logic has_exec(input logic [OP_W-1:0] op);
    return op <= OP_MFLO;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Connection between the control sequencer and the datapath.
//   master: sequencer side (reads ir/con_ff/stop, drives run and all strobes)
//   slave : datapath side (the opposite directions)
interface control_sequencer_if;
  import cpu_pkg::*;

  logic [31:0]     ir;
  logic            con_ff;
  logic            stop;
  logic            run;
  logic            PCout, ZHighout, Zlowout, HIout, LOout, InPortout, MDRout, Cout;
  logic            PCin, MARin, MDRin, IRin, Yin, HIin, LOin, ZHIin, ZLOin, CONin, OutPortin;
  logic            Gra, Grb, Grc, Rin, Rout, BAout;
  logic            Read, Write;
  logic [OP_W-1:0] operation;

  modport master (
    input  ir, con_ff, stop,
    output run,
    output PCout, ZHighout, Zlowout, HIout, LOout, InPortout, MDRout, Cout,
    output PCin, MARin, MDRin, IRin, Yin, HIin, LOin, ZHIin, ZLOin, CONin, OutPortin,
    output Gra, Grb, Grc, Rin, Rout, BAout,
    output Read, Write, operation
  );

  modport slave (
    output ir, con_ff, stop,
    input  run,
    input  PCout, ZHighout, Zlowout, HIout, LOout, InPortout, MDRout, Cout,
    input  PCin, MARin, MDRin, IRin, Yin, HIin, LOin, ZHIin, ZLOin, CONin, OutPortin,
    input  Gra, Grb, Grc, Rin, Rout, BAout,
    input  Read, Write, operation
  );

endinterface

// File: rtl/control_sequencer_step_decoder.sv
// step_decoder: combinational decode of {state, step, opcode, con_ff} into
// the full strobe bundle, plus last_step which marks the final execute step
// of the current instruction.
//   state, step, opcode, con_ff : inputs
//   ctrl                        : strobe bundle (all zero unless listed)
//   last_step                   : high on the last EXEC step
module step_decoder
  import cpu_pkg::*;
(
  input  state_t            state,
  input  logic [STEP_W-1:0] step,
  input  logic [OP_W-1:0]   opcode,
  input  logic              con_ff,
  output ctrl_t             ctrl,
  output logic              last_step
);

  logic is_imm;
  assign is_imm = (opcode == OP_ADDI) || (opcode == OP_ANDI) || (opcode == OP_ORI);

  always_comb begin
    ctrl      = '0;
    last_step = 1'b0;
    case (state)
      FETCH: begin
        case (step)
          T0: begin
            ctrl.PCout = 1'b1; ctrl.MARin = 1'b1;
            ctrl.operation = OP_INCPC; ctrl.ZLOin = 1'b1;
          end
          T1: begin ctrl.Zlowout = 1'b1; ctrl.PCin = 1'b1; ctrl.Read = 1'b1; end
          // Read is held into T2 to cover the RAM's one cycle of latency.
          T2: begin ctrl.Read = 1'b1; ctrl.MDRin = 1'b1; end
          T3: begin ctrl.MDRout = 1'b1; ctrl.IRin = 1'b1; end
          default: ;
        endcase
      end
      EXEC: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_AND, OP_OR, OP_ROR, OP_ROL, OP_SHR, OP_SHRA, OP_SHL,
          OP_ADDI, OP_ANDI, OP_ORI: begin
            case (step)
              T4: begin ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.Yin = 1'b1; end
              T5: begin
                if (is_imm) ctrl.Cout = 1'b1;
                else begin ctrl.Grc = 1'b1; ctrl.Rout = 1'b1; end
                ctrl.operation = opcode; ctrl.ZLOin = 1'b1;
              end
              T6: begin
                ctrl.Zlowout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1;
                last_step = 1'b1;
              end
              default: last_step = 1'b1;
            endcase
          end
          OP_LD, OP_LDI, OP_ST: begin
            // Shared effective-address computation: Rb (or 0 via BAout) + C.
            case (step)
              T4: begin
                ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.BAout = 1'b1; ctrl.Yin = 1'b1;
              end
              T5: begin ctrl.Cout = 1'b1; ctrl.operation = OP_ADD; ctrl.ZLOin = 1'b1; end
              T6: begin
                ctrl.Zlowout = 1'b1;
                if (opcode == OP_LDI) begin
                  ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; last_step = 1'b1;
                end else begin
                  ctrl.MARin = 1'b1;
                end
              end
              T7: begin
                if (opcode == OP_ST) begin
                  ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.Write = 1'b1; last_step = 1'b1;
                end else begin
                  ctrl.Read = 1'b1;
                end
              end
              T8: begin ctrl.Read = 1'b1; ctrl.MDRin = 1'b1; end
              T9: begin
                ctrl.MDRout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; last_step = 1'b1;
              end
              default: last_step = 1'b1;
            endcase
          end
          OP_MUL, OP_DIV: begin
            case (step)
              T4: begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.Yin = 1'b1; end
              T5: begin
                ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.operation = opcode;
                ctrl.ZLOin = 1'b1; ctrl.ZHIin = 1'b1;
              end
              T6: begin ctrl.Zlowout = 1'b1; ctrl.LOin = 1'b1; end
              T7: begin ctrl.ZHighout = 1'b1; ctrl.HIin = 1'b1; last_step = 1'b1; end
              default: last_step = 1'b1;
            endcase
          end
          OP_NEG, OP_NOT: begin
            case (step)
              T4: begin
                ctrl.Grb = 1'b1; ctrl.Rout = 1'b1; ctrl.operation = opcode; ctrl.ZLOin = 1'b1;
              end
              T5: begin
                ctrl.Zlowout = 1'b1; ctrl.Gra = 1'b1; ctrl.Rin = 1'b1; last_step = 1'b1;
              end
              default: last_step = 1'b1;
            endcase
          end
          OP_BR: begin
            case (step)
              T4: begin ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.CONin = 1'b1; end
              T5: begin ctrl.PCout = 1'b1; ctrl.Yin = 1'b1; end
              T6: begin ctrl.Cout = 1'b1; ctrl.operation = OP_ADD; ctrl.ZLOin = 1'b1; end
              // The target is only loaded into PC when the condition held.
              T7: begin
                ctrl.Zlowout = con_ff; ctrl.PCin = con_ff; last_step = 1'b1;
              end
              default: last_step = 1'b1;
            endcase
          end
          OP_JAL: begin
            case (step)
              T4: begin ctrl.PCout = 1'b1; ctrl.Grb = 1'b1; ctrl.Rin = 1'b1; end
              T5: begin
                ctrl.Gra = 1'b1; ctrl.Rout = 1'b1; ctrl.PCin = 1'b1; last_step = 1'b1;
              end
              default: last_step = 1'b1;
            endcase
          end
          // Single-step instructions: strobes at T4, then done.
          OP_JR, OP_IN, OP_OUT, OP_MFHI, OP_MFLO: begin
            last_step = 1'b1;
            if (step == T4) begin
              ctrl.Gra = 1'b1;
              case (opcode)
                OP_JR:   begin ctrl.Rout = 1'b1; ctrl.PCin = 1'b1; end
                OP_IN:   begin ctrl.InPortout = 1'b1; ctrl.Rin = 1'b1; end
                OP_OUT:  begin ctrl.Rout = 1'b1; ctrl.OutPortin = 1'b1; end
                OP_MFHI: begin ctrl.HIout = 1'b1; ctrl.Rin = 1'b1; end
                default: begin ctrl.LOout = 1'b1; ctrl.Rin = 1'b1; end
              endcase
            end
          end
          default: last_step = 1'b1;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: hardwired control unit for the bus-based CPU datapath.
// Holds the state/step registers and the next-state logic; strobes come from
// step_decoder as a combinational decode of the registered state and step
// and the IR opcode.
//   clk : system clock, rising edge
//   clr : asynchronous active-high reset
//   bus : master side of control_sequencer_if (ir, con_ff, stop in;
//         run and every datapath strobe out)
module control_sequencer
  import cpu_pkg::*;
(
  input  logic                clk,
  input  logic                clr,
  control_sequencer_if.master bus
);

  state_t            state;
  logic [STEP_W-1:0] step;
  logic [OP_W-1:0]   opcode;
  ctrl_t             dec;
  ctrl_t             ctrl;
  logic              last_step;
  logic              stop_now;
  logic              unused_ir;

  assign opcode    = bus.ir[31:27];
  assign unused_ir = ^bus.ir[26:0];

  step_decoder u_dec (
    .state     (state),
    .step      (step),
    .opcode    (opcode),
    .con_ff    (bus.con_ff),
    .ctrl      (dec),
    .last_step (last_step)
  );

  // A halt request at T0 suppresses the fetch strobes of that cycle so no
  // new instruction is started.
  assign stop_now = (state == FETCH) && (step == T0) && bus.stop;
  assign ctrl     = stop_now ? '0 : dec;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state <= RESET;
      step  <= T0;
    end else begin
      case (state)
        RESET: begin
          state <= FETCH;
          step  <= T0;
        end
        FETCH: begin
          case (step)
            T0: if (bus.stop) state <= HALT; else step <= T1;
            T1: step <= T2;
            T2: step <= T3;
            T3: begin
              if (opcode == OP_HALT) begin
                state <= HALT;
                step  <= T0;
              end else if (has_exec(opcode)) begin
                state <= EXEC;
                step  <= T4;
              end else begin
                step  <= T0;
              end
            end
            default: step <= T0;
          endcase
        end
        EXEC: begin
          if (last_step) begin
            state <= FETCH;
            step  <= T0;
          end else begin
            step <= step + STEP_W'(1);
          end
        end
        default: begin
          state <= HALT;
          step  <= T0;
        end
      endcase
    end
  end

  assign bus.run       = (state == FETCH) || (state == EXEC);
  assign bus.PCout     = ctrl.PCout;
  assign bus.ZHighout  = ctrl.ZHighout;
  assign bus.Zlowout   = ctrl.Zlowout;
  assign bus.HIout     = ctrl.HIout;
  assign bus.LOout     = ctrl.LOout;
  assign bus.InPortout = ctrl.InPortout;
  assign bus.MDRout    = ctrl.MDRout;
  assign bus.Cout      = ctrl.Cout;
  assign bus.PCin      = ctrl.PCin;
  assign bus.MARin     = ctrl.MARin;
  assign bus.MDRin     = ctrl.MDRin;
  assign bus.IRin      = ctrl.IRin;
  assign bus.Yin       = ctrl.Yin;
  assign bus.HIin      = ctrl.HIin;
  assign bus.LOin      = ctrl.LOin;
  assign bus.ZHIin     = ctrl.ZHIin;
  assign bus.ZLOin     = ctrl.ZLOin;
  assign bus.CONin     = ctrl.CONin;
  assign bus.OutPortin = ctrl.OutPortin;
  assign bus.Gra       = ctrl.Gra;
  assign bus.Grb       = ctrl.Grb;
  assign bus.Grc       = ctrl.Grc;
  assign bus.Rin       = ctrl.Rin;
  assign bus.Rout      = ctrl.Rout;
  assign bus.BAout     = ctrl.BAout;
  assign bus.Read      = ctrl.Read;
  assign bus.Write     = ctrl.Write;
  assign bus.operation = ctrl.operation;

endmodule

// File: tb/tb_control_sequencer.sv
// Testbench for control_sequencer: table of per-instruction strobe masks,
// directed corner sequences (halt, stop, clr mid-instruction) and random
// instructions checked against a text-described micro-step model.
module tb_control_sequencer;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic clr;
  int   total = 0;
  int   bad   = 0;

  control_sequencer_if bus ();
  control_sequencer dut (.clk(clk), .clr(clr), .bus(bus));

  always #5 clk = ~clk;

  ctrl_t obs;
  always_comb begin
    obs = '0;
    obs.PCout = bus.PCout; obs.ZHighout = bus.ZHighout; obs.Zlowout = bus.Zlowout;
    obs.HIout = bus.HIout; obs.LOout = bus.LOout; obs.InPortout = bus.InPortout;
    obs.MDRout = bus.MDRout; obs.Cout = bus.Cout; obs.PCin = bus.PCin;
    obs.MARin = bus.MARin; obs.MDRin = bus.MDRin; obs.IRin = bus.IRin;
    obs.Yin = bus.Yin; obs.HIin = bus.HIin; obs.LOin = bus.LOin;
    obs.ZHIin = bus.ZHIin; obs.ZLOin = bus.ZLOin; obs.CONin = bus.CONin;
    obs.OutPortin = bus.OutPortin; obs.Gra = bus.Gra; obs.Grb = bus.Grb;
    obs.Grc = bus.Grc; obs.Rin = bus.Rin; obs.Rout = bus.Rout;
    obs.BAout = bus.BAout; obs.Read = bus.Read; obs.Write = bus.Write;
    obs.operation = bus.operation;
  end

  task automatic chk_ctrl(input string name, input ctrl_t act, input ctrl_t exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic chk_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic ctrl_t set_one(input ctrl_t c0, input string nm);
    ctrl_t c = c0;
    case (nm)
      "PCout": c.PCout = 1'b1;       "ZHighout": c.ZHighout = 1'b1;
      "Zlowout": c.Zlowout = 1'b1;   "HIout": c.HIout = 1'b1;
      "LOout": c.LOout = 1'b1;       "InPortout": c.InPortout = 1'b1;
      "MDRout": c.MDRout = 1'b1;     "Cout": c.Cout = 1'b1;
      "PCin": c.PCin = 1'b1;         "MARin": c.MARin = 1'b1;
      "MDRin": c.MDRin = 1'b1;       "IRin": c.IRin = 1'b1;
      "Yin": c.Yin = 1'b1;           "HIin": c.HIin = 1'b1;
      "LOin": c.LOin = 1'b1;         "ZHIin": c.ZHIin = 1'b1;
      "ZLOin": c.ZLOin = 1'b1;       "CONin": c.CONin = 1'b1;
      "OutPortin": c.OutPortin = 1'b1; "Gra": c.Gra = 1'b1;
      "Grb": c.Grb = 1'b1;           "Grc": c.Grc = 1'b1;
      "Rin": c.Rin = 1'b1;           "Rout": c.Rout = 1'b1;
      "BAout": c.BAout = 1'b1;       "Read": c.Read = 1'b1;
      "Write": c.Write = 1'b1;
      default: $display("FAIL model_token got=%s want=known", nm);
    endcase
    return c;
  endfunction

  // Space-separated strobe names -> bundle.
  function automatic ctrl_t strobes(input string s, input logic [4:0] opv);
    ctrl_t c = '0;
    int st = 0;
    for (int i = 0; i <= s.len(); i++) begin
      if (i == s.len() || s[i] == 8'h20) begin
        if (i > st) c = set_one(c, s.substr(st, i - 1));
        st = i + 1;
      end
    end
    c.operation = opv;
    return c;
  endfunction

  ctrl_t exp_q[$];

  function automatic void add(input string s, input logic [4:0] opv = 5'd0);
    exp_q.push_back(strobes(s, opv));
  endfunction

  // Full per-cycle strobe list for one instruction; returns 1 for halt.
  function automatic logic build(input logic [4:0] op, input logic con);
    int n = int'(op);
    exp_q.delete();
    add("PCout MARin ZLOin", OP_INCPC);
    add("Zlowout PCin Read");
    add("Read MDRin");
    add("MDRout IRin");
    if (n >= 3 && n <= 11) begin
      add("Grb Rout Yin"); add("Grc Rout ZLOin", op); add("Zlowout Gra Rin");
    end else if (n >= 12 && n <= 14) begin
      add("Grb Rout Yin"); add("Cout ZLOin", op); add("Zlowout Gra Rin");
    end else if (n <= 2) begin
      add("Grb Rout BAout Yin"); add("Cout ZLOin", 5'd3);
      if (n == 1) add("Zlowout Gra Rin");
      else begin
        add("Zlowout MARin");
        if (n == 2) add("Gra Rout Write");
        else begin add("Read"); add("Read MDRin"); add("MDRout Gra Rin"); end
      end
    end else if (n == 15 || n == 16) begin
      add("Gra Rout Yin"); add("Grb Rout ZLOin ZHIin", op);
      add("Zlowout LOin"); add("ZHighout HIin");
    end else if (n == 17 || n == 18) begin
      add("Grb Rout ZLOin", op); add("Zlowout Gra Rin");
    end else if (n == 19) begin
      add("Gra Rout CONin"); add("PCout Yin"); add("Cout ZLOin", 5'd3);
      add(con ? "Zlowout PCin" : "");
    end else if (n == 20) add("Gra Rout PCin");
    else if (n == 21) begin add("PCout Grb Rin"); add("Gra Rout PCin"); end
    else if (n == 22) add("InPortout Gra Rin");
    else if (n == 23) add("Gra Rout OutPortin");
    else if (n == 24) add("HIout Gra Rin");
    else if (n == 25) add("LOout Gra Rin");
    return n == 27;
  endfunction

  // Starts at a T0 cycle; leaves at the next T0 (or first HALT cycle).
  task automatic run_model(input logic [31:0] irv, input logic con, input string tag,
                           output logic halted);
    bus.ir = irv;
    bus.con_ff = con;
    halted = build(irv[31:27], con);
    for (int i = 0; i < exp_q.size(); i++) begin
      #1;
      chk_ctrl($sformatf("%s_c%0d", tag, i), obs, exp_q[i]);
      chk_val($sformatf("%s_run%0d", tag, i), 32'(bus.run), 32'd1);
      @(negedge clk);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    clr = 1'b1;
    bus.stop = 1'b0;
    #1;
    chk_ctrl({tag, "_rst_out"}, obs, '0);
    chk_val({tag, "_rst_run"}, 32'(bus.run), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk_val({tag, "_rel_run"}, 32'(bus.run), 32'd0);
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      #1;
      chk_ctrl($sformatf("%s_out%0d", tag, i), obs, '0);
      chk_val($sformatf("%s_run%0d", tag, i), 32'(bus.run), 32'd0);
      @(negedge clk);
    end
  endtask

  // ---------------- table vectors ----------------
  typedef struct {
    logic [4:0] op;
    logic       con;
    int         len;
    logic [9:0] rd;
    logic [9:0] rin;
    logic [9:0] pcin;
    logic [4:0] op5;
  } vec_t;

  vec_t vecs[11];

  task automatic apply_vec(input vec_t v, input int idx);
    logic [9:0] rd, rin, pcin;
    logic [4:0] op5;
    rd = '0; rin = '0; pcin = '0; op5 = '0;
    bus.ir = {v.op, 27'h0};
    bus.con_ff = v.con;
    for (int i = 0; i < v.len; i++) begin
      #1;
      rd[i] = bus.Read; rin[i] = bus.Rin; pcin[i] = bus.PCin;
      if (i == 5) op5 = bus.operation;
      @(negedge clk);
    end
    #1;
    chk_val($sformatf("vec%0d_read", idx), 32'(rd), 32'(v.rd));
    chk_val($sformatf("vec%0d_rin", idx), 32'(rin), 32'(v.rin));
    chk_val($sformatf("vec%0d_pcin", idx), 32'(pcin), 32'(v.pcin));
    chk_val($sformatf("vec%0d_op5", idx), 32'(op5), 32'(v.op5));
    chk_val($sformatf("vec%0d_len", idx), 32'(bus.PCout & bus.MARin), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic h;
    ctrl_t t0;
    clr = 1'b1;
    bus.ir = '0;
    bus.con_ff = 1'b0;
    bus.stop = 1'b0;

    vecs[0]  = '{5'd3,  1'b0, 7,  10'b0000000110, 10'b0001000000, 10'b0000000010, 5'd3};
    vecs[1]  = '{5'd0,  1'b0, 10, 10'b0110000110, 10'b1000000000, 10'b0000000010, 5'd3};
    vecs[2]  = '{5'd19, 1'b0, 8,  10'b0000000110, 10'b0000000000, 10'b0000000010, 5'd0};
    vecs[3]  = '{5'd19, 1'b1, 8,  10'b0000000110, 10'b0000000000, 10'b0010000010, 5'd0};
    vecs[4]  = '{5'd16, 1'b0, 8,  10'b0000000110, 10'b0000000000, 10'b0000000010, 5'd16};
    vecs[5]  = '{5'd21, 1'b0, 6,  10'b0000000110, 10'b0000010000, 10'b0000100010, 5'd0};
    vecs[6]  = '{5'd26, 1'b0, 4,  10'b0000000110, 10'b0000000000, 10'b0000000010, 5'd0};
    vecs[7]  = '{5'd2,  1'b0, 8,  10'b0000000110, 10'b0000000000, 10'b0000000010, 5'd3};
    vecs[8]  = '{5'd17, 1'b0, 6,  10'b0000000110, 10'b0000100000, 10'b0000000010, 5'd0};
    vecs[9]  = '{5'd29, 1'b0, 4,  10'b0000000110, 10'b0000000000, 10'b0000000010, 5'd0};
    vecs[10] = '{5'd12, 1'b0, 7,  10'b0000000110, 10'b0001000000, 10'b0000000010, 5'd12};

    do_reset("init");

    // add r1,r2,r3 with the full strobe model, then back at T0
    run_model(32'h18918000, 1'b0, "add", h);
    #1;
    chk_val("add_back_t0", 32'(bus.PCout & bus.MARin), 32'd1);

    for (int i = 0; i < 11; i++) apply_vec(vecs[i], i);

    // br both ways and mul through the model
    run_model({5'd19, 27'h0}, 1'b0, "br0", h);
    run_model({5'd19, 27'h0}, 1'b1, "br1", h);
    run_model({5'd16, 27'h0}, 1'b0, "mul", h);

    // halt opcode: run drops after T3 and everything stays quiet
    run_model({OP_HALT, 27'h0}, 1'b0, "halt", h);
    check_quiet("halted", 20);
    do_reset("after_halt");

    // stop at T0: no strobes that cycle, then HALT
    bus.ir = {OP_ADD, 27'h0};
    bus.stop = 1'b1;
    #1;
    chk_ctrl("stop_t0_out", obs, '0);
    @(negedge clk);
    bus.stop = 1'b0;
    check_quiet("stopped", 20);
    do_reset("after_stop");

    // clr asynchronously during ld T7
    bus.ir = {OP_LD, 27'h0};
    bus.con_ff = 1'b0;
    repeat (7) @(negedge clk);
    #1;
    chk_val("ld_t7_read", 32'(bus.Read), 32'd1);
    #1;
    clr = 1'b1;
    #1;
    chk_val("abort_read", 32'(bus.Read), 32'd0);
    chk_ctrl("abort_out", obs, '0);
    chk_val("abort_run", 32'(bus.run), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    #1;
    chk_ctrl("abort_rel_out", obs, '0);
    @(negedge clk);
    #1;
    t0 = strobes("PCout MARin ZLOin", OP_INCPC);
    chk_ctrl("abort_restart_t0", obs, t0);

    // random instruction stream
    for (int k = 0; k < 150; k++) begin
      logic [4:0] op;
      logic       con;
      op  = 5'($urandom_range(0, 31));
      con = 1'($urandom_range(0, 1));
      run_model({op, 27'($urandom)}, con, $sformatf("rnd%0d", k), h);
      if (h) begin
        check_quiet($sformatf("rndhalt%0d", k), 3);
        do_reset($sformatf("rndrst%0d", k));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
